// File: rtl/dsp_post_adder_acc.sv
// dsp_post_adder_acc: post-adder / accumulator stage of the DSP slice.
// Computes Z +/- (X + CIN) under OPMODE control. It owns the P, CYI and
// CARRYOUT registers, and P feeds back into the X and Z muxes to form
// the accumulator.
// Optional feature: define DSP_POST_ADD_OVF_EN to add the signed-overflow
// flag and its `ovf` output port.
module dsp_post_adder_acc #(
  parameter int    PREG        = 1,
  parameter int    CARRYINREG  = 1,
  parameter int    CARRYOUTREG = 1,
  parameter string CARRYINSEL  = "OPMODE5"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_p,
  input  logic        ce_carryin,
  input  logic [7:0]  opmode,
  input  logic [35:0] m,
  input  logic [47:0] c,
  input  logic [17:0] d,
  input  logic [17:0] a,
  input  logic [17:0] b,
  input  logic [47:0] pcin,
  input  logic        carryin,
  output logic [47:0] p,
  output logic [47:0] pcout,
  output logic        carryout
`ifdef DSP_POST_ADD_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");

  logic [47:0] p_q, p_d;
  logic        co_q, co_d;
  logic        cyi_q, cyi_d;
  logic [47:0] x_mux, z_mux;
  logic        cin;
  logic [48:0] x_cin;
  logic [48:0] result;

  // opmode[4] and opmode[6] belong to the pre-adder; d[17:12] is not part of DAB.
  logic unused_bits;
  assign unused_bits = ^{opmode[6], opmode[4], d[17:12]};

  // X and Z operand selection; X=2 and Z=2 always read the internal P register.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    x_mux = '0;
    z_mux = '0;
    unique case (opmode[1:0])
      2'd0: x_mux = '0;
      2'd1: x_mux = {{12{m[35]}}, m};
      2'd2: x_mux = p_q;
      2'd3: x_mux = {d[11:0], a, b};
    endcase
    unique case (opmode[3:2])
      2'd0: z_mux = '0;
      2'd1: z_mux = pcin;
      2'd2: z_mux = p_q;
      2'd3: z_mux = c;
    endcase
  end

  // Carry-in source selection and the 49-bit add/subtract datapath.
  always_comb begin
    cyi_d  = CIN_FROM_PORT ? carryin : opmode[5];
    cin    = (CARRYINREG != 0) ? cyi_q : cyi_d;
    x_cin  = {1'b0, x_mux} + 49'(cin);
    result = opmode[7] ? ({1'b0, z_mux} - x_cin) : ({1'b0, z_mux} + x_cin);
    p_d    = result[47:0];
    co_d   = result[48];
  end

  // P and CARRYOUT registers: async clear, load on ce_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      p_q  <= '0;
      co_q <= 1'b0;
    end else if (ce_p) begin
      p_q  <= p_d;
      co_q <= co_d;
    end
  end

  // CYI register: async clear, load on ce_carryin independently of ce_p.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyi_q <= 1'b0;
    else if (ce_carryin) cyi_q <= cyi_d;
  end

  assign p        = (PREG != 0) ? p_q : p_d;
  assign pcout    = p;
  assign carryout = (CARRYOUTREG != 0) ? co_q : co_d;

`ifdef DSP_POST_ADD_OVF_EN
  logic [47:0] xc;
  logic        ovf_q, ovf_d;

  // Signed overflow of Z +/- (X+CIN) taken as 48-bit two's complement values.
  always_comb begin
    xc = x_cin[47:0];
    if (opmode[7]) ovf_d = (z_mux[47] != xc[47]) && (result[47] != z_mux[47]);
    else           ovf_d = (z_mux[47] == xc[47]) && (result[47] != z_mux[47]);
  end

  // Overflow register: tracks P, not sticky.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (ce_p) ovf_q <= ovf_d;
  end

  assign ovf = (PREG != 0) ? ovf_q : ovf_d;
`endif

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Testbench for dsp_post_adder_acc: two instances with complementary
// parameter sets, a queue-based scoreboard fed by an arithmetic reference
// model, directed vectors for the documented scenarios, then random traffic.
module tb_dsp_post_adder_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_p, ce_carryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] c, pcin;
  logic [17:0] d, a, b;
  logic        carryin;

  logic [47:0] p1, pcout1, p2, pcout2;
  logic        co1, co2;
`ifdef DSP_POST_ADD_OVF_EN
  logic        ovf1, ovf2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Instance 1: registered P/CARRYOUT, unregistered carry-in from opmode[5].
  dsp_post_adder_acc #(.PREG(1), .CARRYINREG(0), .CARRYOUTREG(1), .CARRYINSEL("OPMODE5")) u_dut1 (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_carryin(ce_carryin), .opmode(opmode),
    .m(m), .c(c), .d(d), .a(a), .b(b), .pcin(pcin), .carryin(carryin),
    .p(p1), .pcout(pcout1), .carryout(co1)
`ifdef DSP_POST_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  // Instance 2: combinational P/CARRYOUT, registered carry-in from the port.
  dsp_post_adder_acc #(.PREG(0), .CARRYINREG(1), .CARRYOUTREG(0), .CARRYINSEL("CARRYIN")) u_dut2 (
    .clk(clk), .rst(rst), .ce_p(ce_p), .ce_carryin(ce_carryin), .opmode(opmode),
    .m(m), .c(c), .d(d), .a(a), .b(b), .pcin(pcin), .carryin(carryin),
    .p(p2), .pcout(pcout2), .carryout(co2)
`ifdef DSP_POST_ADD_OVF_EN
    , .ovf(ovf2)
`endif
  );

  typedef struct { bit preg; bit cinreg; bit coreg; bit cin_port; } cfg_t;
  typedef struct { logic [47:0] p; logic co; logic ovf; logic cyi; } st_t;
  typedef struct {
    logic [47:0] p1; logic co1; logic ovf1;
    logic [47:0] p2; logic co2; logic ovf2;
  } exp_t;

  cfg_t cfg [2];
  st_t  st  [2];
  exp_t sb_q [$];

  localparam longint M48   = 64'hFFFF_FFFF_FFFF;
  localparam longint TWO48 = 64'h1_0000_0000_0000;
  localparam longint SMAX  = 64'h7FFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx48(input longint v);
    return (v >= TWO48 / 2) ? v - TWO48 : v;
  endfunction

  // Reference: Z +/- (X + CIN) in plain integer arithmetic on current inputs.
  function automatic void model_eval(input cfg_t cf, input st_t s, output logic [47:0] r,
                                     output logic co, output logic ov, output logic sel);
    longint xv, zv, cv, sum, xc, t;
    case (opmode[1:0])
      2'd0: xv = 0;
      2'd1: xv = longint'($signed(m)) & M48;
      2'd2: xv = longint'(s.p);
      default: xv = longint'({d[11:0], a, b});
    endcase
    case (opmode[3:2])
      2'd0: zv = 0;
      2'd1: zv = longint'(pcin);
      2'd2: zv = longint'(s.p);
      default: zv = longint'(c);
    endcase
    sel = cf.cin_port ? carryin : opmode[5];
    cv  = cf.cinreg ? longint'(s.cyi) : longint'(sel);
    if (!opmode[7]) begin
      sum = zv + xv + cv;
      co  = (sum >= TWO48);
    end else begin
      sum = zv - (xv + cv);
      co  = (sum < 0);
    end
    r  = sum[47:0];
    xc = (xv + cv) & M48;
    t  = opmode[7] ? sx48(zv) - sx48(xc) : sx48(zv) + sx48(xc);
    ov = (t > SMAX) || (t < -(SMAX + 1));
  endfunction

  // Expected outputs for the current inputs and model state.
  task automatic push();
    exp_t e;
    logic [47:0] r [2];
    logic co [2], ov [2], sel [2];
    for (int i = 0; i < 2; i++) model_eval(cfg[i], st[i], r[i], co[i], ov[i], sel[i]);
    e.p1  = cfg[0].preg  ? st[0].p   : r[0];
    e.co1 = cfg[0].coreg ? st[0].co  : co[0];
    e.ovf1 = cfg[0].preg ? st[0].ovf : ov[0];
    e.p2  = cfg[1].preg  ? st[1].p   : r[1];
    e.co2 = cfg[1].coreg ? st[1].co  : co[1];
    e.ovf2 = cfg[1].preg ? st[1].ovf : ov[1];
    sb_q.push_back(e);
  endtask

  // Advance one clock edge and apply it to the model (inputs still stable).
  task automatic tick();
    logic [47:0] r;
    logic co, ov, sel;
    @(posedge clk);
    #1;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        model_eval(cfg[i], st[i], r, co, ov, sel);
        if (ce_p) begin
          st[i].p = r; st[i].co = co; st[i].ovf = ov;
        end
        if (ce_carryin) st[i].cyi = sel;
      end
    end
  endtask

  task automatic step();
    push();
    tick();
  endtask

  task automatic set_dab(input logic [47:0] v);
    d = {6'b0, v[47:36]};
    a = v[35:18];
    b = v[17:0];
  endtask

  task automatic clear_model();
    for (int i = 0; i < 2; i++) st[i] = '{p: '0, co: 1'b0, ovf: 1'b0, cyi: 1'b0};
  endtask

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("p_reg", p1, e.p1);
      check("pcout_reg", pcout1, e.p1);
      check("co_reg", co1, e.co1);
      check("p_comb", p2, e.p2);
      check("pcout_comb", pcout2, e.p2);
      check("co_comb", co2, e.co2);
`ifdef DSP_POST_ADD_OVF_EN
      check("ovf_reg", ovf1, e.ovf1);
      check("ovf_comb", ovf2, e.ovf2);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg[0] = '{preg: 1'b1, cinreg: 1'b0, coreg: 1'b1, cin_port: 1'b0};
    cfg[1] = '{preg: 1'b0, cinreg: 1'b1, coreg: 1'b0, cin_port: 1'b1};
    clear_model();
    rst = 1'b1; ce_p = 1'b1; ce_carryin = 1'b1; opmode = '0;
    m = '0; c = '0; d = '0; a = '0; b = '0; pcin = '0; carryin = 1'b0;
    tick(); tick();
    #1 rst = 1'b0;

    // Load a known P, then reset asynchronously mid-cycle.
    opmode = 8'h03;
    set_dab(48'h1234_5678_9ABC);
    step();
    check("load_p", p1, 48'h1234_5678_9ABC);
    #6 rst = 1'b1;
    clear_model();
    #1;
    check("rst_p", p1, 48'h0);
    check("rst_pcout", pcout1, 48'h0);
    check("rst_co", co1, 1'b0);
    check("rst_comb_p", p2, 48'h1234_5678_9ABC);
    tick();
    #1 rst = 1'b0;

    // Accumulate M=5 from a fresh P, then hold with ce_p low.
    opmode = 8'h09; m = 36'd5;
    for (int i = 0; i < 4; i++) begin
      step();
      check("acc", p1, 48'(5 * (i + 1)));
    end
    ce_p = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("acc_hold", p1, 48'd20);
    end
    ce_p = 1'b1;

    // Subtract with carry-in from opmode[5].
    opmode = 8'hAD; c = 48'd100; m = 36'hF_FFFF_FFFD;
    step();
    check("sub_p", p1, 48'd102);
    c = 48'd0; m = 36'd1;
    step();
    check("sub_neg_p", p1, 48'hFFFF_FFFF_FFFE);
    check("sub_borrow", co1, 1'b1);

    // Wrap-around and signed overflow.
    opmode = 8'h0F; c = 48'hFFFF_FFFF_FFFF; set_dab(48'd1);
    step();
    check("wrap_p", p1, 48'h0);
    check("wrap_co", co1, 1'b1);
`ifdef DSP_POST_ADD_OVF_EN
    check("wrap_ovf", ovf1, 1'b0);
`endif
    c = 48'h7FFF_FFFF_FFFF;
    step();
    check("ovf_p", p1, 48'h8000_0000_0000);
    check("ovf_co", co1, 1'b0);
`ifdef DSP_POST_ADD_OVF_EN
    check("ovf_flag", ovf1, 1'b1);
`endif

    // Cascade passthrough on the unregistered instance.
    opmode = 8'h04; pcin = 48'hABCD_EF01_2345;
    #1;
    check("casc_p", p2, 48'hABCD_EF01_2345);
    check("casc_pcout", pcout2, 48'hABCD_EF01_2345);
    step();

    // CYI delay: carry-in port pulse appears one edge later, gated by ce_carryin.
    opmode = 8'h00; carryin = 1'b1;
    step();
    carryin = 1'b0;
    #1 check("cyi_pulse", p2, 48'd1);
    step();
    check("cyi_clear", p2, 48'd0);
    ce_carryin = 1'b0; carryin = 1'b1;
    step();
    check("cyi_gated", p2, 48'd0);
    carryin = 1'b0;
    step();
    check("cyi_gated2", p2, 48'd0);
    ce_carryin = 1'b1;

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      opmode     = 8'($urandom());
      m          = 36'({$urandom(), $urandom()});
      pcin       = 48'({$urandom(), $urandom()});
      {d, a, b}  = 54'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0: c = 48'hFFFF_FFFF_FFFF;
        1: c = 48'h7FFF_FFFF_FFFF;
        default: c = 48'({$urandom(), $urandom()});
      endcase
      carryin    = 1'($urandom());
      ce_p       = ($urandom_range(0, 7) != 0);
      ce_carryin = 1'($urandom());
      step();
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
